// File: rtl/clk_divider_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Channel configuration is carried at a fixed wide width and narrowed by each user.
package clk_divider_pkg;

    localparam int DEFAULT_BASE = 200000;
    localparam int CFG_BASE_W   = 32;
    localparam int CFG_FAC_W    = 8;

    typedef struct packed {
        logic [CFG_BASE_W-1:0] base;
        logic [CFG_FAC_W-1:0]  factor;
    } ch_cfg_t;

    // Half-period length; a zero result is clamped to one so a channel never stalls.
    function automatic logic [CFG_BASE_W-1:0] eff_half(input logic [CFG_BASE_W-1:0] base,
                                                       input logic [CFG_FAC_W-1:0]  factor);
        logic [CFG_BASE_W-1:0] shifted;
        shifted = base >> factor;
        return (shifted == '0) ? CFG_BASE_W'(1) : shifted;
    endfunction

endpackage

// File: rtl/clk_divider_chan.sv
// One divider channel: half-period counter, live/shadow configuration,
// start/park sequencing and alignment to a global restart pulse.
module clk_divider_chan #(
    parameter int CNT_W        = 27,
    parameter int FAC_W        = 3,
    parameter int DEFAULT_BASE = 200000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sync_restart,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_base,
    input  logic [FAC_W-1:0] wr_factor,
    output logic             clk_out,
    output logic             tick,
    output logic             active,
    output logic             pending
);
    import clk_divider_pkg::*;

    localparam ch_cfg_t RESET_CFG = '{base:   CFG_BASE_W'(CNT_W'(DEFAULT_BASE)),
                                      factor: '0};

    ch_cfg_t          live_cfg;
    ch_cfg_t          shadow_cfg;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] half;
    logic             boundary;

    assign half     = CNT_W'(eff_half(live_cfg.base, live_cfg.factor));
    assign boundary = (count == half - CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the shadow is reset too, so a pending flag can never publish stale contents.
            live_cfg   <= RESET_CFG;
            shadow_cfg <= RESET_CFG;
            count      <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            active     <= 1'b0;
            pending    <= 1'b0;
        end else begin
            // NOTE: tick defaults low each cycle so it is a single-cycle pulse by construction.
            tick <= 1'b0;

            // Writes are only granted while nothing is pending, so they never collide with a publish.
            if (wr) begin
                shadow_cfg <= '{base: CFG_BASE_W'(wr_base), factor: CFG_FAC_W'(wr_factor)};
                pending    <= 1'b1;
            end

            if (!active) begin
                count   <= '0;
                clk_out <= 1'b0;
                if (pending) begin
                    live_cfg <= shadow_cfg;
                    pending  <= 1'b0;
                end
                if (en) active <= 1'b1;
            end else if (!en && !clk_out) begin
                active <= 1'b0;
                count  <= '0;
            end else if (sync_restart) begin
                count   <= '0;
                clk_out <= 1'b0;
                if (pending) begin
                    live_cfg <= shadow_cfg;
                    pending  <= 1'b0;
                end
            end else if (boundary) begin
                count   <= '0;
                clk_out <= !clk_out;
                tick    <= !clk_out;
                // Only reached with clk_out high when en is low: this is the parking fall.
                if (!en) active <= 1'b0;
                if (pending) begin
                    live_cfg <= shadow_cfg;
                    pending  <= 1'b0;
                end
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable divided-clock and tick generator.
// Demuxes the configuration port to the channels and reports per-channel readiness.
module clk_divider_multi #(
    parameter int NCH          = 4,
    parameter int CNT_W        = 27,
    parameter int FAC_W        = 3,
    parameter int DEFAULT_BASE = clk_divider_pkg::DEFAULT_BASE,
    localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NCH-1:0]   en,
    input  logic             sync_restart,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_base,
    input  logic [FAC_W-1:0] cfg_factor,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   active
);
    localparam int NPAD = 2 ** CH_W;

    logic [NCH-1:0]  pending;
    logic [NPAD-1:0] pending_pad;

    // Unused channel indices read as not pending, so writes to them are accepted and dropped.
    assign pending_pad = NPAD'(pending);
    assign cfg_ready   = !pending_pad[cfg_ch];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        logic wr;
        assign wr = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));

        clk_divider_chan #(
            .CNT_W        (CNT_W),
            .FAC_W        (FAC_W),
            .DEFAULT_BASE (DEFAULT_BASE)
        ) u_chan (
            .clk          (clk),
            .reset_n      (reset_n),
            .en           (en[gi]),
            .sync_restart (sync_restart),
            .wr           (wr),
            .wr_base      (cfg_base),
            .wr_factor    (cfg_factor),
            .clk_out      (clk_out[gi]),
            .tick         (tick[gi]),
            .active       (active[gi]),
            .pending      (pending[gi])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi: table of configurations plus
// hand-written sequences for reconfiguration, parking, restart and reset.
module tb_clk_divider_multi;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;
    localparam int FAC_W = 3;
    localparam int DEFB  = 8;

    logic             clk;
    logic             reset_n;
    logic [NCH-1:0]   en;
    logic             sync_restart;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_base;
    logic [FAC_W-1:0] cfg_factor;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   active;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [CNT_W-1:0] base;
        logic [FAC_W-1:0] factor;
        int               exp_half;
    } vec_t;

    clk_divider_multi #(
        .NCH          (NCH),
        .CNT_W        (CNT_W),
        .FAC_W        (FAC_W),
        .DEFAULT_BASE (DEFB)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .sync_restart (sync_restart),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_base     (cfg_base),
        .cfg_factor   (cfg_factor),
        .clk_out      (clk_out),
        .tick         (tick),
        .active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (n_err=%0d)", n_err);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int ch, input int max, output int n);
        n = 0;
        do begin
            tick_clk();
            n++;
        end while (tick[ch] !== 1'b1 && n < max);
    endtask

    task automatic cfg_write(input int ch, input int base, input int factor);
        cfg_ch     = 2'(ch);
        cfg_base   = CNT_W'(base);
        cfg_factor = FAC_W'(factor);
        cfg_valid  = 1'b1;
        #1;
        check("cfg_ready_before_write", cfg_ready, 1);
        tick_clk();
        cfg_valid = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int   n;
        int   ticks;

        vecs[0] = '{base: 8'd12,  factor: 3'd1, exp_half: 6};
        vecs[1] = '{base: 8'd255, factor: 3'd5, exp_half: 7};
        vecs[2] = '{base: 8'd0,   factor: 3'd0, exp_half: 1};
        vecs[3] = '{base: 8'd4,   factor: 3'd3, exp_half: 1};
        vecs[4] = '{base: 8'd3,   factor: 3'd1, exp_half: 1};
        vecs[5] = '{base: 8'd5,   factor: 3'd2, exp_half: 1};
        vecs[6] = '{base: 8'd7,   factor: 3'd0, exp_half: 7};
        vecs[7] = '{base: 8'd8,   factor: 3'd0, exp_half: 8};

        reset_n      = 1'b0;
        en           = '0;
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;
        cfg_ch       = '0;
        cfg_base     = '0;
        cfg_factor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        tick_clk();

        check("reset_clk_out", clk_out, 0);
        check("reset_tick", tick, 0);
        check("reset_active", active, 0);
        check("reset_cfg_ready", cfg_ready, 1);

        // Channel 0 at reset config: H=8, period 16, first rise 8 cycles after active.
        en[0] = 1'b1;
        for (int k = 0; k <= 34; k++) begin
            tick_clk();
            if (k == 0) check("a_active0", active[0], 1);
            check("a_clk_out0", clk_out[0], (k / 8) % 2);
            check("a_tick0", tick[0], (k % 16 == 8) ? 1 : 0);
        end

        // Now on the third low cycle (count=2): write base=8 factor=2.
        cfg_ch     = 2'd0;
        cfg_base   = 8'd8;
        cfg_factor = 3'd2;
        cfg_valid  = 1'b1;
        #1;
        check("b_ready_accept", cfg_ready, 1);
        for (int k = 35; k <= 44; k++) begin
            tick_clk();
            cfg_valid = 1'b0;
            #1;
            if (k < 40) begin
                check("b_ready_stall", cfg_ready, 0);
                check("b_clk_low", clk_out[0], 0);
                check("b_tick_low", tick[0], 0);
            end else begin
                check("b_ready_free", cfg_ready, 1);
                check("b_clk_h2", clk_out[0], (((k - 40) / 2) % 2 == 0) ? 1 : 0);
                check("b_tick_h2", tick[0], ((k - 40) % 4 == 0) ? 1 : 0);
            end
        end

        // Clamp to H=1: toggles every cycle, tick every other cycle.
        cfg_write(0, 4, 3);
        repeat (3) tick_clk();
        check("c_ready", cfg_ready, 1);
        wait_tick(0, 8, n);
        check("c_tick_found", tick[0], 1);
        for (int j = 1; j <= 4; j++) begin
            tick_clk();
            check("c_clk_h1", clk_out[0], (j % 2 == 0) ? 1 : 0);
            check("c_tick_h1", tick[0], (j % 2 == 0) ? 1 : 0);
        end

        // Table: program idle channel 1, measure first rise and period.
        foreach (vecs[i]) begin
            cfg_write(1, int'(vecs[i].base), int'(vecs[i].factor));
            tick_clk();
            check("t_ready_after_idle_apply", cfg_ready, 1);
            en[1] = 1'b1;
            wait_tick(1, 40, n);
            check("t_first_rise", n, vecs[i].exp_half + 1);
            wait_tick(1, 40, n);
            check("t_period", n, 2 * vecs[i].exp_half);
            en[1] = 1'b0;
            n = 0;
            while (active[1] !== 1'b0 && n < 40) begin
                tick_clk();
                n++;
            end
            check("t_parked_clk", clk_out[1], 0);
            check("t_parked_active", active[1], 0);
        end

        // Park on channel 1 (H=8): en dropped on the second high cycle.
        en[1] = 1'b1;
        wait_tick(1, 40, n);
        check("d_first_rise", n, 9);
        tick_clk();
        en[1] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick_clk();
            check("d_high_hold", clk_out[1], 1);
            check("d_active_hold", active[1], 1);
        end
        tick_clk();
        check("d_parked_clk", clk_out[1], 0);
        check("d_parked_active", active[1], 0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            tick_clk();
            if (tick[1] === 1'b1 || active[1] === 1'b1) ticks++;
        end
        check("d_no_ticks_after_park", ticks, 0);

        // Restart: channel 0 at H=8, channel 2 at H=3, channel 3 idle.
        cfg_write(0, 8, 0);
        cfg_ch = 2'd0;
        n = 0;
        #1;
        while (cfg_ready !== 1'b1 && n < 10) begin
            tick_clk();
            n++;
        end
        check("e_ch0_applied", cfg_ready, 1);
        cfg_write(2, 3, 0);
        tick_clk();
        en[2] = 1'b1;
        repeat (5) tick_clk();
        sync_restart = 1'b1;
        tick_clk();
        sync_restart = 1'b0;
        check("e_clk0_restart", clk_out[0], 0);
        check("e_clk2_restart", clk_out[2], 0);
        check("e_tick_restart", tick, 0);
        check("e_active_restart", active, 4'b0101);
        for (int k = 1; k <= 10; k++) begin
            tick_clk();
            check("e_clk0", clk_out[0], (k / 8) % 2);
            check("e_tick0", tick[0], (k % 16 == 8) ? 1 : 0);
            check("e_clk2", clk_out[2], (k / 3) % 2);
            check("e_tick2", tick[2], (k % 6 == 3) ? 1 : 0);
            check("e_idle3", {active[3], clk_out[3], tick[3]}, 0);
        end

        // Asynchronous reset at the start of a channel-0 high phase.
        wait_tick(0, 40, n);
        check("f_tick_before_reset", tick[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("f_async_clk_out", clk_out, 0);
        check("f_async_tick", tick, 0);
        check("f_async_active", active, 0);
        en = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tick_clk();
        cfg_ch = 2'd2;
        #1;
        check("f_ready_after_reset", cfg_ready, 1);
        en[2] = 1'b1;
        wait_tick(2, 40, n);
        check("f_ch2_default_half", n, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
